// File: rtl/xio_bus_pkg.sv
// Shared types and helpers for the A8 bus capture slice: FSM states, the
// write-queue entry layout and the address window decode.
package xio_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SKIP     = 3'd1,
        RD_WAIT  = 3'd2,
        RD_DRIVE = 3'd3,
        WR_WAIT  = 3'd4
    } bus_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_txn_t;

    // True when every address bit selected by mask equals the window base.
    function automatic logic win_match(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] mask);
        return ((addr ^ base) & mask) == 16'h0000;
    endfunction

endpackage

// File: rtl/xio_sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers; a pop in the same
// cycle as a push on a full queue frees the slot the push lands in.
module xio_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/a8_bus_capture.sv
// Captures A8 bus cycles hitting the decoded window: writes go into a FIFO,
// reads raise a request and drive the returned byte back onto the bus.
module a8_bus_capture
    import xio_bus_pkg::*;
#(
    parameter logic [15:0] WIN_BASE   = 16'hD500,
    parameter logic [15:0] WIN_MASK   = 16'hFF00,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  IDLE_DATA  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a8_addr,
    input  logic        a8_rw_n,
    input  logic [7:0]  a8_data_in,
    input  logic        a8_addr_strobe,
    input  logic        a8_write_strobe,
    input  logic        a8_read_strobe,
    input  logic        a8_clk_falling,
    output logic [7:0]  a8_data_out,
    output logic        a8_data_oe,
    output logic        rd_req_valid,
    output logic [7:0]  rd_req_addr,
    input  logic        rd_rsp_valid,
    input  logic [7:0]  rd_rsp_data,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ready,
    output logic        err_overflow,
    output logic        err_late
);
    bus_state_t r_state;
    logic [7:0] r_addr_lo;
    logic       r_rsp_got;
    logic [7:0] r_rsp_data;
    logic [7:0] r_data_out;
    logic       r_data_oe;
    logic       r_rd_req_valid;
    logic       r_err_overflow;
    logic       r_err_late;

    wr_txn_t    w_push_txn;
    wr_txn_t    w_head;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic       w_drop;

    assign w_push           = (r_state == WR_WAIT) && a8_write_strobe;
    assign w_pop            = !w_empty && wr_ready;
    assign w_drop           = w_push && w_full && !w_pop;
    assign w_push_txn.addr  = r_addr_lo;
    assign w_push_txn.data  = a8_data_in;

    xio_sync_fifo #(
        .WIDTH ($bits(wr_txn_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_txn),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    // Bus-cycle FSM with its registered bus/request outputs and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr_lo      <= 8'h00;
            r_rsp_got      <= 1'b0;
            r_rsp_data     <= 8'h00;
            r_data_out     <= 8'h00;
            r_data_oe      <= 1'b0;
            r_rd_req_valid <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_late     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (a8_addr_strobe) begin
                        r_addr_lo <= a8_addr[7:0];
                        r_rsp_got <= 1'b0;
                        if (!win_match(a8_addr, WIN_BASE, WIN_MASK)) begin
                            r_state <= SKIP;
                        end else if (a8_rw_n) begin
                            r_state        <= RD_WAIT;
                            r_rd_req_valid <= 1'b1;
                        end else begin
                            r_state <= WR_WAIT;
                        end
                    end
                end
                SKIP: begin
                    if (a8_clk_falling) begin
                        r_state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (a8_read_strobe) begin
                        // A response in the strobe cycle itself still counts.
                        r_state        <= RD_DRIVE;
                        r_data_oe      <= 1'b1;
                        r_rd_req_valid <= 1'b0;
                        if (rd_rsp_valid && !r_rsp_got) begin
                            r_data_out <= rd_rsp_data;
                        end else if (r_rsp_got) begin
                            r_data_out <= r_rsp_data;
                        end else begin
                            r_data_out <= IDLE_DATA;
                            r_err_late <= 1'b1;
                        end
                    end else if (a8_clk_falling) begin
                        r_state        <= IDLE;
                        r_rd_req_valid <= 1'b0;
                    end else if (rd_rsp_valid && !r_rsp_got) begin
                        r_rsp_data     <= rd_rsp_data;
                        r_rsp_got      <= 1'b1;
                        r_rd_req_valid <= 1'b0;
                    end
                end
                RD_DRIVE: begin
                    if (a8_clk_falling) begin
                        r_state    <= IDLE;
                        r_data_oe  <= 1'b0;
                        r_data_out <= 8'h00;
                    end
                end
                WR_WAIT: begin
                    if (a8_clk_falling) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_drop) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign a8_data_out  = r_data_out;
    assign a8_data_oe   = r_data_oe;
    assign rd_req_valid = r_rd_req_valid;
    assign rd_req_addr  = r_addr_lo;
    assign wr_valid     = !w_empty;
    assign wr_addr      = w_empty ? 8'h00 : w_head.addr;
    assign wr_data      = w_empty ? 8'h00 : w_head.data;
    assign err_overflow = r_err_overflow;
    assign err_late     = r_err_late;

endmodule

// File: tb/tb_a8_bus_capture.sv
// Randomised, model-checked bench for a8_bus_capture: bus cycles are played
// as per-cycle event offsets and compared against a queue-based model.
`timescale 1ns/100ps
module tb_a8_bus_capture;
    localparam int DEPTH = 8;
    localparam int NONE  = 999;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a8_addr = 16'h0000;
    logic        a8_rw_n = 1'b0;
    logic [7:0]  a8_data_in = 8'h00;
    logic        a8_addr_strobe = 1'b0;
    logic        a8_write_strobe = 1'b0;
    logic        a8_read_strobe = 1'b0;
    logic        a8_clk_falling = 1'b0;
    logic [7:0]  a8_data_out;
    logic        a8_data_oe;
    logic        rd_req_valid;
    logic [7:0]  rd_req_addr;
    logic        rd_rsp_valid = 1'b0;
    logic [7:0]  rd_rsp_data = 8'h00;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready = 1'b0;
    logic        err_overflow;
    logic        err_late;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] q[$];
    bit          exp_ovf = 1'b0;
    bit          exp_late = 1'b0;

    a8_bus_capture dut (
        .clk(clk), .rst(rst), .a8_addr(a8_addr), .a8_rw_n(a8_rw_n),
        .a8_data_in(a8_data_in), .a8_addr_strobe(a8_addr_strobe),
        .a8_write_strobe(a8_write_strobe), .a8_read_strobe(a8_read_strobe),
        .a8_clk_falling(a8_clk_falling), .a8_data_out(a8_data_out),
        .a8_data_oe(a8_data_oe), .rd_req_valid(rd_req_valid),
        .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_data(rd_rsp_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .err_overflow(err_overflow),
        .err_late(err_late)
    );

    always #2.5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit in_win(input logic [15:0] a);
        return (a >= 16'hD500) && (a <= 16'hD5FF);
    endfunction

    // Advance one clock; the model applies reset, then pop-before-push.
    task automatic step(input bit push, input logic [7:0] pa, input logic [7:0] pd);
        if (rst) begin
            q.delete();
            exp_ovf  = 1'b0;
            exp_late = 1'b0;
        end else begin
            if (q.size() > 0 && wr_ready) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back({pa, pd});
                else exp_ovf = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_bus();
        a8_addr_strobe = 1'b0; a8_write_strobe = 1'b0; a8_read_strobe = 1'b0;
        a8_clk_falling = 1'b0; rd_rsp_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        clear_bus();
        wr_ready = 1'b0;
        rst = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        rst = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, input int rsp_at, input int strobe_at,
                            input int fall_at, input logic [7:0] rsp_byte, input int rst_at,
                            input string nm);
        bit inw, drv, reqv;
        logic [7:0] byte_exp;
        inw = in_win(addr); drv = 1'b0; byte_exp = 8'h00;
        a8_addr = addr; a8_rw_n = 1'b1; a8_addr_strobe = 1'b1;
        wr_ready = 1'($urandom_range(0, 1));
        step(1'b0, 8'h00, 8'h00);
        a8_addr_strobe = 1'b0;
        reqv = inw;
        checks++;
        if (rd_req_valid !== reqv) begin
            failures++;
            $display("FAIL %s req_after_addr: got %0b want %0b", nm, rd_req_valid, reqv);
        end
        for (int i = 1; i <= fall_at; i++) begin
            rd_rsp_valid   = 1'(i == rsp_at);
            rd_rsp_data    = (i == rsp_at) ? rsp_byte : 8'($urandom);
            a8_read_strobe = 1'(i == strobe_at);
            a8_clk_falling = 1'(i == fall_at);
            rst            = 1'(i == rst_at);
            wr_ready       = 1'($urandom_range(0, 1));
            step(1'b0, 8'h00, 8'h00);
            if (i == rst_at) begin
                drv = 1'b0; reqv = 1'b0;
            end else begin
                if (inw && i == strobe_at) begin
                    drv = 1'b1;
                    byte_exp = (rsp_at <= strobe_at) ? rsp_byte : 8'hFF;
                    if (rsp_at > strobe_at) exp_late = 1'b1;
                end
                if (i == rsp_at || i == strobe_at || i == fall_at) reqv = 1'b0;
                if (i == fall_at) drv = 1'b0;
            end
            checks++;
            if (a8_data_oe !== drv) begin
                failures++;
                $display("FAIL %s oe@%0d: got %0b want %0b", nm, i, a8_data_oe, drv);
            end
            if (drv) begin
                checks++;
                if (a8_data_out !== byte_exp) begin
                    failures++;
                    $display("FAIL %s data@%0d: got %h want %h", nm, i, a8_data_out, byte_exp);
                end
            end
            checks++;
            if (rd_req_valid !== reqv) begin
                failures++;
                $display("FAIL %s req@%0d: got %0b want %0b", nm, i, rd_req_valid, reqv);
            end
            if (reqv) begin
                checks++;
                if (rd_req_addr !== addr[7:0]) begin
                    failures++;
                    $display("FAIL %s req_addr: got %h want %h", nm, rd_req_addr, addr[7:0]);
                end
            end
            checks++;
            if (err_late !== exp_late) begin
                failures++;
                $display("FAIL %s err_late@%0d: got %0b want %0b", nm, i, err_late, exp_late);
            end
            if (i == rst_at) break;
        end
        clear_bus();
        step(1'b0, 8'h00, 8'h00);
        checks++;
        if (a8_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL %s oe_after: got %0b want 0", nm, a8_data_oe);
        end
    endtask

    // rdy_mode: 0 never ready, 1 always, 2 random, 3 only in the strobe cycle.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int strobe_at,
                             input int fall_at, input int rdy_mode, input string nm);
        bit inw;
        inw = in_win(addr);
        a8_addr = addr; a8_rw_n = 1'b0; a8_addr_strobe = 1'b1;
        wr_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        step(1'b0, 8'h00, 8'h00);
        a8_addr_strobe = 1'b0;
        for (int i = 1; i <= fall_at; i++) begin
            a8_write_strobe = 1'(i == strobe_at);
            a8_data_in      = (i == strobe_at) ? data : 8'($urandom);
            a8_clk_falling  = 1'(i == fall_at);
            case (rdy_mode)
                0:       wr_ready = 1'b0;
                1:       wr_ready = 1'b1;
                2:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = 1'(i == strobe_at);
            endcase
            step(inw && (i == strobe_at), addr[7:0], data);
            checks++;
            if (wr_valid !== (q.size() != 0)) begin
                failures++;
                $display("FAIL %s wr_valid@%0d: got %0b want %0b", nm, i, wr_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({wr_addr, wr_data} !== q[0]) begin
                    failures++;
                    $display("FAIL %s head@%0d: got %h want %h", nm, i, {wr_addr, wr_data}, q[0]);
                end
            end
            checks++;
            if (err_overflow !== exp_ovf || a8_data_oe !== 1'b0 || rd_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s flags@%0d: ovf=%0b oe=%0b req=%0b want ovf=%0b oe=0 req=0",
                         nm, i, err_overflow, a8_data_oe, rd_req_valid, exp_ovf);
            end
        end
        clear_bus();
    endtask

    task automatic drain(input string nm, output logic [15:0] got[$]);
        got.delete();
        wr_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH + 4; k++) begin
            if (!wr_valid) break;
            got.push_back({wr_addr, wr_data});
            step(1'b0, 8'h00, 8'h00);
        end
        wr_ready = 1'b0;
        checks++;
        if (wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s drain_bound: wr_valid still %0b", nm, wr_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a8_data_out, a8_data_oe, rd_req_valid, rd_req_addr, wr_valid, wr_addr, wr_data,
             err_overflow, err_late} !== 38'h0) begin
            failures++;
            $display("FAIL reset_outputs: got oe=%0b dout=%h req=%0b raddr=%h wv=%0b wa=%h wd=%h ovf=%0b late=%0b want all 0",
                     a8_data_oe, a8_data_out, rd_req_valid, rd_req_addr, wr_valid, wr_addr,
                     wr_data, err_overflow, err_late);
        end
    endtask

    task automatic test_read_on_time();
        bus_read(16'hD512, 40, 82, 90, 8'h5A, NONE, "read_on_time");
    endtask

    task automatic test_read_late();
        bus_read(16'hD500, NONE, 5, 8, 8'h00, NONE, "read_late");
        checks++;
        if (err_late !== 1'b1) begin
            failures++;
            $display("FAIL read_late_sticky: got %0b want 1", err_late);
        end
    endtask

    task automatic test_read_same_cycle();
        do_reset();
        bus_read(16'hD5A7, 3, 3, 6, 8'h3C, NONE, "read_same_cycle");
        bus_read(16'hD5A8, 5, 3, 7, 8'h99, NONE, "read_rsp_after_strobe");
    endtask

    task automatic test_write();
        bus_write(16'hD5FF, 8'hC3, 2, 4, 0, "write_basic");
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 8'hFF || wr_data !== 8'hC3) begin
            failures++;
            $display("FAIL write_basic_head: got %0b %h %h want 1 ff c3", wr_valid, wr_addr, wr_data);
        end
    endtask

    task automatic test_out_of_window();
        logic [15:0] got[$];
        do_reset();
        bus_write(16'hD600, 8'h11, 2, 3, 0, "write_out_win");
        bus_read(16'hD400, 2, 3, 5, 8'h22, NONE, "read_out_win");
        drain("out_win", got);
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL out_win_entries: got %0d want 0", got.size());
        end
    endtask

    task automatic test_overflow();
        logic [15:0] sent[9];
        logic [15:0] got[$];
        do_reset();
        for (int k = 0; k < 9; k++) begin
            sent[k] = {8'(k * 17), 8'($urandom)};
            bus_write({8'hD5, sent[k][15:8]}, sent[k][7:0], 1, 2, 0, "overflow");
        end
        checks++;
        if (err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag: got %0b want 1", err_overflow);
        end
        drain("overflow", got);
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL overflow_count: got %0d want 8", got.size());
        end
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== sent[k]) begin
                failures++;
                $display("FAIL overflow_order[%0d]: got %h want %h", k, got[k], sent[k]);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] sent[9];
        logic [15:0] got[$];
        do_reset();
        for (int k = 0; k < 9; k++) begin
            sent[k] = {8'(k + 8'h40), 8'($urandom)};
            bus_write({8'hD5, sent[k][15:8]}, sent[k][7:0], 1, 2, (k == 8) ? 3 : 0, "full_pop");
        end
        checks++;
        if (err_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_flag: got %0b want 0", err_overflow);
        end
        drain("full_pop", got);
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL full_pop_count: got %0d want 8", got.size());
        end
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== sent[k + 1]) begin
                failures++;
                $display("FAIL full_pop_order[%0d]: got %h want %h", k, got[k], sent[k + 1]);
            end
        end
    endtask

    task automatic test_reset_in_drive();
        bus_read(16'hD520, 2, 4, 12, 8'h77, 7, "rst_in_drive");
        bus_read(16'hD521, 2, 4, 6, 8'h78, NONE, "after_rst_read");
    endtask

    task automatic test_short_cycle();
        logic [15:0] got[$];
        do_reset();
        bus_read(16'hD530, 2, NONE, 4, 8'h55, NONE, "short_read");
        bus_write(16'hD531, 8'h66, NONE, 3, 0, "short_write");
        drain("short", got);
        checks++;
        if (got.size() != 0 || err_late !== 1'b0) begin
            failures++;
            $display("FAIL short_cycle: got entries=%0d late=%0b want 0 0", got.size(), err_late);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, got[$];
        int rsp_at, strobe_at, fall_at;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = {8'hD5, 8'($urandom)};
                2:       a = {($urandom_range(0, 1) != 0) ? 8'hD4 : 8'hD6, 8'($urandom)};
                default: a = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) != 0) begin
                rsp_at    = ($urandom_range(0, 3) == 0) ? NONE : int'($urandom_range(1, 8));
                strobe_at = ($urandom_range(0, 7) == 0) ? NONE : int'($urandom_range(2, 8));
                fall_at   = (strobe_at == NONE) ? int'($urandom_range(2, 8))
                                                : strobe_at + int'($urandom_range(1, 3));
                bus_read(a, rsp_at, strobe_at, fall_at, 8'($urandom), NONE, "rand_read");
            end else begin
                strobe_at = ($urandom_range(0, 5) == 0) ? NONE : int'($urandom_range(1, 4));
                fall_at   = (strobe_at == NONE) ? int'($urandom_range(1, 5))
                                                : strobe_at + int'($urandom_range(0, 2));
                bus_write(a, 8'($urandom), strobe_at, fall_at, 2, "rand_write");
            end
        end
        drain("rand", got);
    endtask

    initial begin
        test_reset();
        test_read_on_time();
        test_read_late();
        test_read_same_cycle();
        test_write();
        test_out_of_window();
        test_overflow();
        test_full_pop();
        test_reset_in_drive();
        test_short_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
